// File: rtl/adau_cfg.sv
// rtl/adau_cfg.sv - ADAU1761 power-up register sequencer over I2C
//
// On start, walks an external table of {reg_addr[15:0], value[7:0]} entries
// and writes each one to the codec as a 4-byte I2C write
// (dev addr + W, reg_addr hi, reg_addr lo, value). Entries with
// reg_addr 16'hFFFF are timed waits of value*65536 cycles instead of writes.
// A NACK on any byte aborts the whole sequence with error set.
//
// Ports:
//   AMSCK            clock (same domain as the I2S receiver)
//   rst              synchronous active-high reset
//   start            one-cycle request, ignored while busy
//   rom_idx          index of the current table entry
//   rom_data         combinational table word for rom_idx
//   scl              I2C clock, push-pull, registered
//   sda_o            SDA drive value, constant 0
//   sda_t            1 releases SDA, 0 drives sda_o; registered
//   sda_i            SDA pad input
//   busy/done/error  sequence status; error is valid while done=1
module adau_cfg #(
  parameter int         CLK_DIV  = 245,
  parameter logic [6:0] DEV_ADDR = 7'h3B,
  parameter int         NUM_REGS = 32,
  parameter int         IDX_W    = 6
) (
  input  logic             AMSCK,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [23:0]      rom_data,
  output logic             scl,
  output logic             sda_o,
  output logic             sda_t,
  input  logic             sda_i,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [1:0]       qtr, qtr_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [1:0]       byte_cnt, byte_cnt_d;
  logic [7:0]       shift, shift_d;
  logic [23:0]      entry, entry_d;
  logic [23:0]      dly_cnt, dly_d;
  logic [IDX_W-1:0] idx_d;
  logic             busy_d, done_d, error_d;
  logic             scl_d, sda_t_d;
  logic             timed, q_end, elem_end, advance;

  assign sda_o = 1'b0;

  always_comb begin
    state_d    = state;
    div_d      = '0;
    qtr_d      = '0;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    shift_d    = shift;
    entry_d    = entry;
    dly_d      = dly_cnt;
    idx_d      = rom_idx;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    advance    = 1'b0;
    scl_d      = 1'b1;
    sda_t_d    = 1'b1;

    // Quarter timing only runs in bus states; elsewhere it parks at 0 so
    // every bus element starts cleanly at Q0.
    timed    = (state == S_START) || (state == S_BYTE) || (state == S_ACK) ||
               (state == S_STOP)  || (state == S_GAP);
    q_end    = (div_cnt == DIV_LAST);
    elem_end = q_end && (qtr == 2'd3);
    if (timed) begin
      div_d = q_end ? '0 : div_cnt + DIV_W'(1);
      qtr_d = q_end ? qtr + 2'd1 : qtr;
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        entry_d = rom_data;
        if (rom_data[23:8] == 16'hFFFF) begin
          // A zero-length wait moves straight on; otherwise DELAY occupies
          // exactly value*65536 cycles.
          if (rom_data[7:0] == 8'd0) advance = 1'b1;
          else begin
            dly_d   = {rom_data[7:0], 16'h0000} - 24'd1;
            state_d = S_DELAY;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (elem_end) begin
          state_d    = S_BYTE;
          shift_d    = {DEV_ADDR, 1'b0};
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      S_BYTE: begin
        if (elem_end) begin
          if (bit_cnt == 3'd7) state_d = S_ACK;
          else begin
            bit_cnt_d = bit_cnt + 3'd1;
            shift_d   = {shift[6:0], 1'b0};
          end
        end
      end
      S_ACK: begin
        // Sample on the last cycle of Q2, while SCL is high and settled.
        if ((qtr == 2'd2) && q_end && sda_i) error_d = 1'b1;
        if (elem_end) begin
          if (error || (byte_cnt == 2'd3)) state_d = S_STOP;
          else begin
            state_d    = S_BYTE;
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    shift_d = entry[23:16];
              2'd1:    shift_d = entry[15:8];
              default: shift_d = entry[7:0];
            endcase
          end
        end
      end
      S_STOP:  if (elem_end) state_d = S_GAP;
      S_GAP:   if (elem_end) advance = 1'b1;
      S_DELAY: begin
        if (dly_cnt == 24'd0) advance = 1'b1;
        else dly_d = dly_cnt - 24'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared end-of-entry rule: a NACK or the last entry finishes the run.
    if (advance) begin
      if (error || (rom_idx == LAST_IDX)) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d   = rom_idx + IDX_W'(1);
        state_d = S_FETCH;
      end
    end

    // Bus pins are decoded from the next state so the registered pins line
    // up with the state/quarter they belong to.
    case (state_d)
      S_START: sda_t_d = ~qtr_d[1];
      S_BYTE: begin
        scl_d   = qtr_d[1];
        sda_t_d = shift_d[7];
      end
      S_ACK:   scl_d = qtr_d[1];
      S_STOP: begin
        scl_d   = (qtr_d != 2'd0);
        sda_t_d = qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge AMSCK) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      entry    <= '0;
      dly_cnt  <= '0;
      rom_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      scl      <= 1'b1;
      sda_t    <= 1'b1;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      qtr      <= qtr_d;
      bit_cnt  <= bit_cnt_d;
      byte_cnt <= byte_cnt_d;
      shift    <= shift_d;
      entry    <= entry_d;
      dly_cnt  <= dly_d;
      rom_idx  <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      scl      <= scl_d;
      sda_t    <= sda_t_d;
    end
  end

endmodule

// File: doc/adau_cfg.md
# adau_cfg

Power-up configuration sequencer for the ADAU1761 codec on the audio path. On `start`, it walks an external register table and writes each entry to the codec over I2C, with optional timed waits such as the PLL-lock delay. It asserts `done` once the codec is configured and the I2S capture path can be trusted. It runs on the same 98.304 MHz domain as the I2S receiver.

## Interface
Parameters:
- `CLK_DIV`, 245: clock cycles per SCL quarter-bit; 245 gives ≈100 kHz SCL. Legal range is ≥2.
- `DEV_ADDR`, 7'h3B: 7-bit I2C device address.
- `NUM_REGS`, 32: number of table entries, 1..2^`IDX_W`.
- `IDX_W`, 6: width of the table index.

Ports:
- `AMSCK` in 1: clock, 98.304 MHz.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins the sequence. Ignored while `busy`=1.
- `rom_idx` out `IDX_W`: index of the current table entry.
- `rom_data` in 24: combinational table read for `rom_idx`, laid out as {reg_addr[15:0], value[7:0]}.
- `scl` out 1: I2C clock, push-pull. No clock stretching is supported.
- `sda_o` out 1: always 0.
- `sda_t` out 1: 1 releases SDA (pulled high), 0 drives SDA to `sda_o`.
- `sda_i` in 1: SDA pad input.
- `busy` out 1: sequence in progress.
- `done` out 1: sequence finished, held high until the next accepted `start`.
- `error` out 1: a NACK was received. Valid when `done`=1.

## Operation
- The reset values are:
  - `scl`=1, `sda_t`=1, `busy`=0, `done`=0, `error`=0, `rom_idx`=0.
  - State is IDLE and all counters are 0.
- Reset asserted mid-transfer releases the bus on the next edge. No STOP is generated.
- On an accepted `start`:
  - `busy` goes to 1, `done` to 0, `error` to 0, `rom_idx` to 0.
  - The FSM moves to FETCH.
- State machine:
  - IDLE → FETCH when `start` is accepted.
  - FETCH latches `rom_data`.
    - If reg_addr equals 16'hFFFF, go to DELAY.
    - Otherwise go to START.
  - START → BYTE, with the byte register loaded with {`DEV_ADDR`,0}.
  - BYTE shifts out 8 bits, MSB first, then goes to ACK.
  - ACK:
    - `sda_i`=1 (NACK): set `error`=1 and go to STOP.
    - `sda_i`=0 after byte 0, 1 or 2: load the next byte (reg_addr[15:8], reg_addr[7:0], value) and go to BYTE.
    - `sda_i`=0 after byte 3: go to STOP.
  - STOP → GAP.
  - GAP:
    - If `error`=1, go to DONE.
    - Otherwise, if `rom_idx`=`NUM_REGS`-1, go to DONE.
    - Otherwise increment `rom_idx` and go to FETCH.
  - DELAY waits value×65536 cycles; value=0 means zero wait. It then applies the same next-entry or DONE rule as GAP.
  - DONE sets `busy`=0 and `done`=1, then goes to IDLE.
- A NACK aborts the whole sequence. The remaining entries are not written.

## Timing
- A quarter is `CLK_DIV` cycles. Every bus element is 4 quarters, Q0..Q3.
- Data or ACK bit:
  - `scl`=0 in Q0–Q1 and 1 in Q2–Q3.
  - SDA changes only on the first cycle of Q0.
  - In ACK, `sda_t`=1 and `sda_i` is sampled on the last cycle of Q2.
- START:
  - SDA released and `scl`=1 in Q0–Q1.
  - SDA driven 0 in Q2–Q3 with `scl`=1.
  - `scl` falls at the next Q0.
- STOP:
  - Q0: `scl`=0, SDA=0.
  - Q1: `scl`=1, SDA=0.
  - Q2–Q3: `scl`=1, SDA released.
- GAP is 4 quarters with the bus idle: `scl`=1, SDA released.
- One register write is START + 36 bit cells + STOP + GAP = 156 quarters = 156×`CLK_DIV` cycles, plus 1 FETCH cycle.
- `busy` rises on the cycle after `start`. `done` rises on the cycle after the final GAP or DELAY ends.
- `scl` and `sda_t` are registered outputs, so the bus is glitch-free.

## Test plan
All scenarios use `CLK_DIV`=2.
- Reset during the middle of a byte → next cycle `scl`=1, `sda_t`=1, `busy`=0. A later `start` runs a full sequence from index 0.
- `NUM_REGS`=1, entry 24'h4000_01, slave model ACKs every byte → bus decodes to the bytes 0x76, 0x40, 0x00, 0x01. `done`=1 and `error`=0 exactly 313 cycles after `start`.
- `NUM_REGS`=3 with entries 24'h4015_01, 24'hFFFF_02, 24'h4016_00 → two writes separated by a 131072-cycle bus-idle gap. `rom_idx` sequences 0, 1, 2.
- Slave NACKs the reg_addr[7:0] byte of entry 0 → STOP follows immediately, then `error`=1 and `done`=1. No further START appears and `rom_idx` stays 0.
- `start` pulsed again while `busy`=1 → ignored, and the bus trace is identical to the single-start run.
- Protocol checker across all runs → SDA never changes while `scl`=1 except during START and STOP, and every ACK sample falls in Q2.
